// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration: datapath width and ln-arbiter sizing/tag types.
package fpga_cfg_pkg;

    localparam int unsigned FP_WIDTH               = 32;
    localparam int unsigned FP_FRAC                = 16;

    localparam int unsigned LN_ARB_N_REQ           = 4;
    localparam int unsigned LN_ARB_MAX_OUTSTANDING = 4;
    localparam int unsigned LN_ARB_ID_W            = $clog2(LN_ARB_N_REQ);

    typedef logic [LN_ARB_ID_W-1:0] ln_tag_t;

    // Pointer width that stays legal for a depth of 1.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fx_ln_arbiter_tag_fifo.sv
// In-order requester-tag FIFO; push and pop may occur in the same cycle, push allowed when full only with a pop.
module fx_tag_fifo
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = LN_ARB_MAX_OUTSTANDING,
    parameter int unsigned W     = LN_ARB_ID_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fx_ln_arbiter.sv
// Shares one fixed-point ln unit between N_REQ requesters and routes results back in issue order.
// Build option FX_LN_ARB_FIXED_PRIO_EN: lowest index always wins (no round-robin pointer).
module fx_ln_arbiter
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned WIDTH           = FP_WIDTH,
    parameter int unsigned N_REQ           = LN_ARB_N_REQ,
    parameter int unsigned MAX_OUTSTANDING = LN_ARB_MAX_OUTSTANDING,
    parameter int unsigned ID_W            = $clog2(N_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req_valid,
    output logic [N_REQ-1:0]                     req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0]          req_a,
    output logic [N_REQ-1:0]                     rsp_valid,
    input  logic [N_REQ-1:0]                     rsp_ready,
    output logic [WIDTH-1:0]                     rsp_result,
    output logic                                 ln_valid,
    input  logic                                 ln_ready,
    output logic [WIDTH-1:0]                     ln_a,
    input  logic                                 ln_valid_out,
    output logic                                 ln_ready_in,
    input  logic [WIDTH-1:0]                     ln_result,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_orphan
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             err_orphan_q, err_orphan_d;
    logic [ID_W-1:0]  prio_start;
    logic [ID_W-1:0]  gnt_idx;
    int unsigned      cand;
    logic             any_req;
    logic             can_issue;
    logic             issue;
    logic             ret;
    logic             orphan_hit;
    logic             tag_full, tag_empty;
    logic [ID_W-1:0]  tag_head;

`ifdef FX_LN_ARB_FIXED_PRIO_EN
    assign prio_start = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    assign prio_start = rr_ptr_q;

    // Pointer advances past the winner only on an accepted issue.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = ID_W'((32'(gnt_idx) + 32'd1) % N_REQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // First asserted request at or after prio_start, wrapping.
    always_comb begin
        any_req = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(prio_start) + i) % N_REQ;
            if (!any_req && req_valid[ID_W'(cand)]) begin
                any_req = 1'b1;
                gnt_idx = ID_W'(cand);
            end
        end
    end

    // Eligibility uses registered state only, so rsp_ready never reaches req_ready.
    always_comb begin
        can_issue = !rst && (outstanding_q < CNT_W'(MAX_OUTSTANDING)) && !tag_full;
        ln_valid  = can_issue && any_req;
        ln_a      = ln_valid ? req_a[gnt_idx] : '0;
        issue     = ln_valid && ln_ready;
        req_ready = issue ? (N_REQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        rsp_valid   = '0;
        ln_ready_in = 1'b1;
        ret         = 1'b0;
        orphan_hit  = 1'b0;
        rsp_result  = ln_result;
        if (tag_empty) begin
            orphan_hit = ln_valid_out;
        end else begin
            ln_ready_in         = rsp_ready[tag_head];
            rsp_valid[tag_head] = ln_valid_out && !rst;
            ret                 = ln_valid_out && rsp_ready[tag_head];
        end
    end

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(ret);
        err_orphan_d  = err_orphan_q | orphan_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            err_orphan_q  <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    assign outstanding = outstanding_q;
    assign err_orphan  = err_orphan_q;

    fx_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (gnt_idx),
        .pop       (ret),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

endmodule
